// File: rtl/instruction_pipe_reg.sv
// instruction_pipe_reg
//   Carries decoded instruction fields from the decoder towards the register file, ALU and
//   data memory through DEPTH register stages, each tagged with a valid bit. Supports stall
//   (hold all stages), flush (kill all stages) and bubble insertion (in_valid=0). A bubble
//   always carries all-zero fields, so its enables and jump control can never fire. A
//   saturating debug counter records capture edges that leave the last stage empty.
//
// Ports
//   CLK, RST                         clock; synchronous active-high reset on the capture edge
//   *_in, in_valid                   decoded instruction fields and their valid flag
//   stall, flush                     hazard/jump control (RST > flush > stall > shift)
//   a_addr .. reg_addr, out_valid    last-stage fields, driven straight from registers
//   bubble_cnt                       saturating count of edges ending with out_valid == 0
`timescale 1ns / 1ps

module instruction_pipe_reg #(
  parameter int unsigned RA_W        = 4,
  parameter int unsigned IMM_W       = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned ALU_W       = 3,
  parameter int unsigned JCTL_W      = 2,
  parameter int unsigned DEPTH       = 1,
  parameter int unsigned CAPTURE_NEG = 1,
  parameter int unsigned BUB_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [RA_W-1:0]   a_addr_in,
  input  logic [RA_W-1:0]   b_addr_in,
  input  logic [RA_W-1:0]   c_addr_in,
  input  logic [IMM_W-1:0]  immediate_val_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ALU_W-1:0]  alu_control_in,
  input  logic [JCTL_W-1:0] JCTL_in,
  input  logic              im_sel_in,
  input  logic              reg_write_in,
  input  logic              data_read_in,
  input  logic              data_write_in,
  input  logic              reg_addr_in,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [RA_W-1:0]   a_addr,
  output logic [RA_W-1:0]   b_addr,
  output logic [RA_W-1:0]   c_addr,
  output logic [IMM_W-1:0]  immediate_val,
  output logic [ADDR_W-1:0] addr,
  output logic [ALU_W-1:0]  alu_control,
  output logic [JCTL_W-1:0] JCTL,
  output logic              im_sel,
  output logic              reg_write,
  output logic              data_read,
  output logic              data_write,
  output logic              reg_addr,
  output logic              out_valid,
  output logic [BUB_W-1:0]  bubble_cnt
);

  localparam int unsigned FW = 3 * RA_W + IMM_W + ADDR_W + ALU_W + JCTL_W + 5;

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("instruction_pipe_reg: DEPTH must be in 1..4");
  end

  logic [FW-1:0]    stage_q [DEPTH];
  logic [FW-1:0]    stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic [FW-1:0]    in_word;

  // Bubbles enter with zeroed fields so downstream enables stay quiet.
  assign in_word = in_valid ? {a_addr_in, b_addr_in, c_addr_in, immediate_val_in, addr_in,
                               alu_control_in, JCTL_in, im_sel_in, reg_write_in,
                               data_read_in, data_write_in, reg_addr_in}
                            : '0;

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    bub_d   = bub_q;
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_d[i] = '0;
      end
      valid_d = '0;
    end else if (!stall) begin
      stage_d[0] = in_word;
      valid_d[0] = in_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
    // Counts on the resulting last-stage state, including a held empty stage during stall.
    if (!valid_d[DEPTH-1] && (bub_q != {BUB_W{1'b1}})) begin
      bub_d = bub_q + 1'b1;
    end
  end

  if (CAPTURE_NEG != 0) begin : g_neg
    always_ff @(negedge CLK) begin
      if (RST) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= '0;
        end
        valid_q <= '0;
        bub_q   <= '0;
      end else begin
        stage_q <= stage_d;
        valid_q <= valid_d;
        bub_q   <= bub_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= '0;
        end
        valid_q <= '0;
        bub_q   <= '0;
      end else begin
        stage_q <= stage_d;
        valid_q <= valid_d;
        bub_q   <= bub_d;
      end
    end
  end

  assign {a_addr, b_addr, c_addr, immediate_val, addr, alu_control, JCTL, im_sel, reg_write,
          data_read, data_write, reg_addr} = stage_q[DEPTH-1];
  assign out_valid  = valid_q[DEPTH-1];
  assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_instruction_pipe_reg.sv
`timescale 1ns / 1ps

module tb_instruction_pipe_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] a_in, b_in, c_in;
  logic [7:0] imm_in, addr_in;
  logic [2:0] alu_in;
  logic [1:0] j_in;
  logic       ims_in, rw_in, dr_in, dw_in, ra_in, v_in, stall, flush;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // d1: DEPTH=1 negedge; d2: DEPTH=2 negedge; b3: DEPTH=1 posedge, 3-bit bubble counter
  logic [3:0]  d1_a, d1_b, d1_c, d2_a, d2_b, d2_c, b3_a, b3_b, b3_c;
  logic [7:0]  d1_imm, d1_ad, d2_imm, d2_ad, b3_imm, b3_ad;
  logic [2:0]  d1_alu, d2_alu, b3_alu;
  logic [1:0]  d1_j, d2_j, b3_j;
  logic        d1_ims, d1_rw, d1_dr, d1_dw, d1_ra, d1_v;
  logic        d2_ims, d2_rw, d2_dr, d2_dw, d2_ra, d2_v;
  logic        b3_ims, b3_rw, b3_dr, b3_dw, b3_ra, b3_v;
  logic [15:0] d1_bc, d2_bc;
  logic [2:0]  b3_bc;

  instruction_pipe_reg #(.DEPTH(1), .CAPTURE_NEG(1)) u_d1 (
    .CLK(CLK), .RST(RST), .a_addr_in(a_in), .b_addr_in(b_in), .c_addr_in(c_in),
    .immediate_val_in(imm_in), .addr_in(addr_in), .alu_control_in(alu_in), .JCTL_in(j_in),
    .im_sel_in(ims_in), .reg_write_in(rw_in), .data_read_in(dr_in), .data_write_in(dw_in),
    .reg_addr_in(ra_in), .in_valid(v_in), .stall(stall), .flush(flush),
    .a_addr(d1_a), .b_addr(d1_b), .c_addr(d1_c), .immediate_val(d1_imm), .addr(d1_ad),
    .alu_control(d1_alu), .JCTL(d1_j), .im_sel(d1_ims), .reg_write(d1_rw),
    .data_read(d1_dr), .data_write(d1_dw), .reg_addr(d1_ra), .out_valid(d1_v),
    .bubble_cnt(d1_bc)
  );

  instruction_pipe_reg #(.DEPTH(2), .CAPTURE_NEG(1)) u_d2 (
    .CLK(CLK), .RST(RST), .a_addr_in(a_in), .b_addr_in(b_in), .c_addr_in(c_in),
    .immediate_val_in(imm_in), .addr_in(addr_in), .alu_control_in(alu_in), .JCTL_in(j_in),
    .im_sel_in(ims_in), .reg_write_in(rw_in), .data_read_in(dr_in), .data_write_in(dw_in),
    .reg_addr_in(ra_in), .in_valid(v_in), .stall(stall), .flush(flush),
    .a_addr(d2_a), .b_addr(d2_b), .c_addr(d2_c), .immediate_val(d2_imm), .addr(d2_ad),
    .alu_control(d2_alu), .JCTL(d2_j), .im_sel(d2_ims), .reg_write(d2_rw),
    .data_read(d2_dr), .data_write(d2_dw), .reg_addr(d2_ra), .out_valid(d2_v),
    .bubble_cnt(d2_bc)
  );

  instruction_pipe_reg #(.DEPTH(1), .CAPTURE_NEG(0), .BUB_W(3)) u_b3 (
    .CLK(CLK), .RST(RST), .a_addr_in(a_in), .b_addr_in(b_in), .c_addr_in(c_in),
    .immediate_val_in(imm_in), .addr_in(addr_in), .alu_control_in(alu_in), .JCTL_in(j_in),
    .im_sel_in(ims_in), .reg_write_in(rw_in), .data_read_in(dr_in), .data_write_in(dw_in),
    .reg_addr_in(ra_in), .in_valid(v_in), .stall(stall), .flush(flush),
    .a_addr(b3_a), .b_addr(b3_b), .c_addr(b3_c), .immediate_val(b3_imm), .addr(b3_ad),
    .alu_control(b3_alu), .JCTL(b3_j), .im_sel(b3_ims), .reg_write(b3_rw),
    .data_read(b3_dr), .data_write(b3_dw), .reg_addr(b3_ra), .out_valid(b3_v),
    .bubble_cnt(b3_bc)
  );

  // Inputs change just after a negedge, so both capture edges see the same stable values.
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_in();
    a_in = '0; b_in = '0; c_in = '0; imm_in = '0; addr_in = '0; alu_in = '0; j_in = '0;
    ims_in = 0; rw_in = 0; dr_in = 0; dw_in = 0; ra_in = 0; v_in = 0;
    stall = 0; flush = 0;
  endtask

  task automatic do_reset();
    clear_in();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({d1_a, d1_b, d1_c, d1_imm, d1_ad, d1_alu, d1_j, d1_ims, d1_rw, d1_dr, d1_dw, d1_ra,
         d1_v} !== '0) begin
      errors++; $display("FAIL reset_fields_d1: got v=%0b a=%0d rw=%0b, want all 0",
                         d1_v, d1_a, d1_rw);
    end
    checks++;
    if (d1_bc !== 16'd0) begin errors++; $display("FAIL reset_bubble_d1: got %0d want 0", d1_bc); end
    checks++;
    if (d2_v !== 1'b0 || b3_v !== 1'b0) begin
      errors++; $display("FAIL reset_valid_d2_b3: got %0b/%0b want 0/0", d2_v, b3_v);
    end
    // Negedge-capture instance must ignore the posedge; posedge instance must take it.
    v_in = 1; a_in = 4'd6;
    @(posedge CLK); #1;
    checks++;
    if (d1_v !== 1'b0 || d1_a !== 4'd0) begin
      errors++; $display("FAIL posedge_hold_d1: got v=%0b a=%0d want 0/0", d1_v, d1_a);
    end
    checks++;
    if (b3_v !== 1'b1 || b3_a !== 4'd6) begin
      errors++; $display("FAIL posedge_capture_b3: got v=%0b a=%0d want 1/6", b3_v, b3_a);
    end
    @(negedge CLK); #1;
    checks++;
    if (d1_v !== 1'b1 || d1_a !== 4'd6) begin
      errors++; $display("FAIL negedge_capture_d1: got v=%0b a=%0d want 1/6", d1_v, d1_a);
    end
    clear_in();
  endtask

  task automatic test_latency();
    do_reset();
    v_in = 1; a_in = 4'd3; b_in = 4'd5; c_in = 4'd9; rw_in = 1;
    step();
    clear_in();
    checks++;
    if (d1_v !== 1'b1 || d1_a !== 4'd3) begin
      errors++; $display("FAIL latency1_d1: got v=%0b a=%0d want 1/3", d1_v, d1_a);
    end
    checks++;
    if (d2_v !== 1'b0) begin errors++; $display("FAIL latency_early_d2: got v=%0b want 0", d2_v); end
    step();
    checks++;
    if ({d2_a, d2_b, d2_c, d2_rw, d2_v} !== {4'd3, 4'd5, 4'd9, 1'b1, 1'b1}) begin
      errors++; $display("FAIL latency2_d2: got a=%0d b=%0d c=%0d rw=%0b v=%0b want 3/5/9/1/1",
                         d2_a, d2_b, d2_c, d2_rw, d2_v);
    end
    checks++;
    if (d2_bc !== 16'd1) begin errors++; $display("FAIL latency_bubble_d2: got %0d want 1", d2_bc); end
  endtask

  task automatic test_stall();
    do_reset();
    v_in = 1; a_in = 4'd1;
    step();                         // A captured into stage0
    a_in = 4'd2; stall = 1;         // B presented and held during stall
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (d2_v !== 1'b0 || d2_a !== 4'd0) begin
        errors++; $display("FAIL stall_frozen_d2[%0d]: got v=%0b a=%0d want 0/0", k, d2_v, d2_a);
      end
    end
    checks++;
    if (d2_bc !== 16'd4) begin errors++; $display("FAIL stall_bubble_d2: got %0d want 4", d2_bc); end
    stall = 0;
    step();                         // fifth edge: A out, B into stage0
    v_in = 0; a_in = 4'd0;
    checks++;
    if (d2_v !== 1'b1 || d2_a !== 4'd1) begin
      errors++; $display("FAIL stall_a_out_d2: got v=%0b a=%0d want 1/1", d2_v, d2_a);
    end
    step();
    checks++;
    if (d2_v !== 1'b1 || d2_a !== 4'd2) begin
      errors++; $display("FAIL stall_b_out_d2: got v=%0b a=%0d want 1/2", d2_v, d2_a);
    end
    clear_in();
  endtask

  task automatic test_flush();
    do_reset();
    v_in = 1; dw_in = 1; j_in = 2'd1; a_in = 4'd4; imm_in = 8'hA5;
    step();
    step();
    checks++;
    if (d2_v !== 1'b1 || d2_dw !== 1'b1 || d2_j !== 2'd1) begin
      errors++; $display("FAIL flush_full_d2: got v=%0b dw=%0b j=%0d want 1/1/1", d2_v, d2_dw, d2_j);
    end
    stall = 1; flush = 1;
    step();
    checks++;
    if ({d2_a, d2_b, d2_c, d2_imm, d2_ad, d2_alu, d2_j, d2_ims, d2_rw, d2_dr, d2_dw, d2_ra,
         d2_v} !== '0) begin
      errors++; $display("FAIL flush_clear_d2: got v=%0b dw=%0b j=%0d a=%0d imm=%0h want all 0",
                         d2_v, d2_dw, d2_j, d2_a, d2_imm);
    end
    clear_in();
    step();                         // stage0 was flushed too, input on flush edge dropped
    checks++;
    if (d2_v !== 1'b0 || d2_dw !== 1'b0) begin
      errors++; $display("FAIL flush_drop_d2: got v=%0b dw=%0b want 0/0", d2_v, d2_dw);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    v_in = 0; rw_in = 1; dr_in = 1; j_in = 2'd2; a_in = 4'd7;
    step();
    checks++;
    if ({d1_v, d1_rw, d1_dr, d1_j, d1_a} !== '0) begin
      errors++; $display("FAIL bubble_fields_d1: got v=%0b rw=%0b dr=%0b j=%0d a=%0d want 0",
                         d1_v, d1_rw, d1_dr, d1_j, d1_a);
    end
    checks++;
    if (d1_bc !== 16'd1) begin errors++; $display("FAIL bubble_cnt1_d1: got %0d want 1", d1_bc); end
    step();
    checks++;
    if (d1_bc !== 16'd2) begin errors++; $display("FAIL bubble_cnt2_d1: got %0d want 2", d1_bc); end
    clear_in();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 6 || k == 7 || k == 10) begin
        checks++;
        if (b3_bc !== ((k >= 7) ? 3'd7 : 3'(k))) begin
          errors++; $display("FAIL saturate_b3[%0d]: got %0d want %0d", k, b3_bc,
                             (k >= 7) ? 7 : k);
        end
      end
    end
    checks++;
    if (d1_bc !== 16'd10) begin errors++; $display("FAIL count10_d1: got %0d want 10", d1_bc); end
    RST = 1;
    step();
    RST = 0;
    checks++;
    if (b3_bc !== 3'd0 || d1_bc !== 16'd0) begin
      errors++; $display("FAIL saturate_reset: got b3=%0d d1=%0d want 0/0", b3_bc, d1_bc);
    end
  endtask

  initial begin
    clear_in();
    RST = 1'b1;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bubble();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
